// File: rtl/apu_core_package.sv
// Shared APU constants: unit pipeline depths, unit class codes, result flag
// positions and the per-class latency lookup used by the integer responder.
package apu_core_package;

  localparam int PIPE_REG_ADDSUB = 1;
  localparam int PIPE_REG_MULT   = 1;
  localparam int PIPE_REG_CAST   = 1;
  localparam int PIPE_REG_MAC    = 2;
  localparam int PIPE_REG_DIV    = 4;
  localparam int PIPE_REG_SQRT   = 5;

  localparam int APU_MAX_LAT = 5;

  typedef enum logic [2:0] {
    APU_TYPE_ADDSUB = 3'd0,
    APU_TYPE_MULT   = 3'd1,
    APU_TYPE_CAST   = 3'd2,
    APU_TYPE_MAC    = 3'd3,
    APU_TYPE_DIV    = 3'd4,
    APU_TYPE_SQRT   = 3'd5
  } apu_type_e;

  localparam int APU_RFLAG_DZ = 0;
  localparam int APU_RFLAG_OV = 1;
  localparam int APU_RFLAG_NV = 4;

  // Unassigned classes (6, 7) complete in a single cycle with an invalid flag.
  function automatic logic [2:0] apu_lat(input logic [2:0] unit_type);
    case (unit_type)
      APU_TYPE_ADDSUB: apu_lat = 3'(PIPE_REG_ADDSUB);
      APU_TYPE_MULT:   apu_lat = 3'(PIPE_REG_MULT);
      APU_TYPE_CAST:   apu_lat = 3'(PIPE_REG_CAST);
      APU_TYPE_MAC:    apu_lat = 3'(PIPE_REG_MAC);
      APU_TYPE_DIV:    apu_lat = 3'(PIPE_REG_DIV);
      APU_TYPE_SQRT:   apu_lat = 3'(PIPE_REG_SQRT);
      default:         apu_lat = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/apu_int_isqrt.sv
// Combinational floor square root of a 32-bit unsigned value, restoring
// digit-by-digit method producing one root bit per radicand bit pair.
module apu_int_isqrt (
  input  logic [31:0] radicand_i,
  output logic [15:0] root_o
);

  always_comb begin
    logic [33:0] rem;
    logic [17:0] trial;
    logic [15:0] root;
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = 15; i >= 0; i--) begin
      rem   = {rem[31:0], radicand_i[2*i+1 -: 2]};
      trial = {root, 2'b01};
      if (rem >= {16'b0, trial}) begin
        rem  = rem - {16'b0, trial};
        root = {root[14:0], 1'b1};
      end else begin
        root = {root[14:0], 1'b0};
      end
    end
    root_o = root;
  end

endmodule

// File: rtl/apu_int_responder.sv
// APU responder with integer stand-in units: results travel down a short
// slot line and pop out of slot 1 exactly L cycles after their grant.
module apu_int_responder
  import apu_core_package::*;
#(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  parameter int TAG_W            = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               apu_slave_req_i,
  output logic                               apu_slave_gnt_o,
  input  logic [2:0]                         apu_slave_type_i,
  input  logic [APU_WOP_CPU-1:0]             apu_slave_op_i,
  input  logic [APU_NARGS_CPU-1:0][31:0]     apu_slave_operands_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]        apu_slave_flags_i,
  input  logic [TAG_W-1:0]                   apu_slave_tag_i,
  output logic                               apu_slave_rvalid_o,
  output logic [31:0]                        apu_slave_rdata_o,
  output logic [APU_NUSFLAGS_CPU-1:0]        apu_slave_rflags_o,
  output logic [TAG_W-1:0]                   apu_slave_rtag_o,
  output logic                               busy_o
);

  typedef struct packed {
    logic                        valid;
    logic [31:0]                 data;
    logic [APU_NUSFLAGS_CPU-1:0] flags;
    logic [TAG_W-1:0]            tag;
  } slot_t;

  slot_t slot_q [1:APU_MAX_LAT];
  slot_t slot_d [1:APU_MAX_LAT];
  logic [2:0] iter_q, iter_d;

  logic [31:0] a, b, c;
  logic        op0;
  logic [2:0]  lat;
  logic        is_iter;
  logic [7:0]  occ;
  logic        gnt;

  logic [31:0]        sum, diff, prod_lo, quot, rem;
  logic signed [63:0] prod_s;
  logic [15:0]        root;
  logic [31:0]                 res_data;
  logic [APU_NUSFLAGS_CPU-1:0] res_flags;
  logic                        unused_bits;

  assign a       = apu_slave_operands_i[0];
  assign b       = apu_slave_operands_i[1];
  assign c       = apu_slave_operands_i[2];
  assign op0     = apu_slave_op_i[0];
  assign lat     = apu_lat(apu_slave_type_i);
  assign is_iter = (apu_slave_type_i == APU_TYPE_DIV) || (apu_slave_type_i == APU_TYPE_SQRT);

  assign sum     = a + b;
  assign diff    = a - b;
  assign prod_lo = a * b;
  assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign quot    = a / b;
  assign rem     = a % b;

  assign unused_bits = ^{apu_slave_flags_i, apu_slave_op_i[APU_WOP_CPU-1:1], prod_s[31:0]};

  apu_int_isqrt u_isqrt (
    .radicand_i (a),
    .root_o     (root)
  );

  // occ[6] and occ[7] stay zero, so the L=5 class never sees a collision.
  always_comb begin
    occ = '0;
    for (int j = 1; j <= APU_MAX_LAT; j++) occ[j] = slot_q[j].valid;
  end

  assign gnt = rst_n && apu_slave_req_i && !occ[lat + 3'd1] && (!is_iter || (iter_q == 3'd0));
  assign apu_slave_gnt_o = gnt;

  always_comb begin
    res_data  = '0;
    res_flags = '0;
    case (apu_slave_type_i)
      APU_TYPE_ADDSUB: begin
        res_data = op0 ? diff : sum;
        res_flags[APU_RFLAG_OV] = op0 ? ((a[31] != b[31]) && (diff[31] != a[31]))
                                      : ((a[31] == b[31]) && (sum[31] != a[31]));
      end
      APU_TYPE_MULT: res_data = op0 ? prod_s[63:32] : prod_lo;
      APU_TYPE_CAST: res_data = op0 ? {16'b0, a[15:0]} : {{16{a[15]}}, a[15:0]};
      APU_TYPE_MAC:  res_data = prod_lo + c;
      APU_TYPE_DIV: begin
        if (b == 32'd0) begin
          res_data = op0 ? a : 32'hFFFF_FFFF;
          res_flags[APU_RFLAG_DZ] = 1'b1;
        end else begin
          res_data = op0 ? rem : quot;
        end
      end
      APU_TYPE_SQRT: res_data = {16'b0, root};
      default:       res_flags[APU_RFLAG_NV] = 1'b1;
    endcase
  end

  always_comb begin
    for (int j = 1; j < APU_MAX_LAT; j++) slot_d[j] = slot_q[j+1];
    slot_d[APU_MAX_LAT] = '0;
    if (gnt) slot_d[lat] = '{valid: 1'b1, data: res_data, flags: res_flags, tag: apu_slave_tag_i};
  end

  always_comb begin
    iter_d = iter_q;
    if (gnt && is_iter)      iter_d = lat - 3'd1;
    else if (iter_q != 3'd0) iter_d = iter_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j <= APU_MAX_LAT; j++) slot_q[j] <= '0;
      iter_q <= '0;
    end else begin
      for (int j = 1; j <= APU_MAX_LAT; j++) slot_q[j] <= slot_d[j];
      iter_q <= iter_d;
    end
  end

  assign apu_slave_rvalid_o = slot_q[1].valid;
  assign apu_slave_rdata_o  = slot_q[1].data;
  assign apu_slave_rflags_o = slot_q[1].flags;
  assign apu_slave_rtag_o   = slot_q[1].tag;
  assign busy_o             = (|occ) || (iter_q != 3'd0);

endmodule

// File: tb/tb_apu_int_responder.sv
// Directed bench for apu_int_responder: inputs change and outputs are sampled
// around the falling edge, results are compared against hand-computed values.
module tb_apu_int_responder;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic             gnt;
  logic [2:0]       utype;
  logic [5:0]       op;
  logic [2:0][31:0] operands;
  logic [14:0]      dflags;
  logic [5:0]       tag;
  logic             rvalid;
  logic [31:0]      rdata;
  logic [4:0]       rflags;
  logic [5:0]       rtag;
  logic             busy;

  int passed = 0;
  int total  = 0;

  apu_int_responder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .apu_slave_req_i      (req),
    .apu_slave_gnt_o      (gnt),
    .apu_slave_type_i     (utype),
    .apu_slave_op_i       (op),
    .apu_slave_operands_i (operands),
    .apu_slave_flags_i    (dflags),
    .apu_slave_tag_i      (tag),
    .apu_slave_rvalid_o   (rvalid),
    .apu_slave_rdata_o    (rdata),
    .apu_slave_rflags_o   (rflags),
    .apu_slave_rtag_o     (rtag),
    .busy_o               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the middle of the next cycle and apply a request there.
  task automatic drive(input logic [2:0] t, input logic o, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vc, input logic [5:0] tg);
    @(negedge clk);
    req = 1'b1; utype = t; op = {5'b0, o}; tag = tg;
    operands[0] = va; operands[1] = vb; operands[2] = vc;
    dflags = 15'h5A5A;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; utype = 3'd0; op = '0; tag = '0; operands = '0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req = 1'b1; utype = 3'd0; operands[0] = 32'd1; operands[1] = 32'd2;
    #1;
    total++; if (gnt !== 1'b0)     $display("FAIL reset_gnt: got %b want 0", gnt);          else passed++;
    total++; if (rvalid !== 1'b0)  $display("FAIL reset_rvalid: got %b want 0", rvalid);    else passed++;
    total++; if ({rdata, rflags, rtag} !== 43'd0) $display("FAIL reset_outs: got %h/%h/%h want 0/0/0", rdata, rflags, rtag); else passed++;
    total++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);        else passed++;
    idle();
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_addsub();
    drive(3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 6'd3);
    total++; if (gnt !== 1'b1)    $display("FAIL add_gnt: got %b want 1", gnt);          else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL add_early: got %b want 0", rvalid);     else passed++;
    drive(3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 6'd4);
    total++; if (gnt !== 1'b1)    $display("FAIL add_ov_gnt: got %b want 1", gnt);       else passed++;
    total++; if ({rvalid, rdata, rflags, rtag} !== {1'b1, 32'd12, 5'd0, 6'd3})
      $display("FAIL add_result: got v=%b d=%h f=%h t=%0d want v=1 d=0000000c f=00 t=3", rvalid, rdata, rflags, rtag); else passed++;
    drive(3'd0, 1'b1, 32'd3, 32'd5, 32'd0, 6'd5);
    total++; if ({rvalid, rdata, rflags, rtag} !== {1'b1, 32'h8000_0000, 5'b00010, 6'd4})
      $display("FAIL add_overflow: got v=%b d=%h f=%h t=%0d want v=1 d=80000000 f=02 t=4", rvalid, rdata, rflags, rtag); else passed++;
    idle();
    total++; if ({rvalid, rdata, rflags, rtag} !== {1'b1, 32'hFFFF_FFFE, 5'd0, 6'd5})
      $display("FAIL sub_result: got v=%b d=%h f=%h t=%0d want v=1 d=fffffffe f=00 t=5", rvalid, rdata, rflags, rtag); else passed++;
    idle();
    total++; if ({rvalid, busy} !== 2'b00) $display("FAIL add_drain: got rvalid=%b busy=%b want 0 0", rvalid, busy); else passed++;
    $display("addsub: 5+7, 0x7fffffff+1, 3-5 issued");
  endtask

  task automatic test_div_collision();
    drive(3'd4, 1'b0, 32'd100, 32'd7, 32'd0, 6'd1);
    total++; if (gnt !== 1'b1) $display("FAIL div_gnt: got %b want 1", gnt); else passed++;
    idle();
    total++; if (busy !== 1'b1) $display("FAIL div_busy: got %b want 1", busy); else passed++;
    idle();
    drive(3'd1, 1'b0, 32'd6, 32'd7, 32'd0, 6'd2);
    total++; if (gnt !== 1'b0) $display("FAIL mult_blocked: got %b want 0", gnt); else passed++;
    @(negedge clk); #1;
    total++; if (gnt !== 1'b1) $display("FAIL mult_gnt: got %b want 1", gnt); else passed++;
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd14, 6'd1})
      $display("FAIL div_result: got v=%b d=%0d t=%0d want v=1 d=14 t=1", rvalid, rdata, rtag); else passed++;
    idle();
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd42, 6'd2})
      $display("FAIL mult_result: got v=%b d=%0d t=%0d want v=1 d=42 t=2", rvalid, rdata, rtag); else passed++;
    idle();
    total++; if ({rvalid, busy} !== 2'b00) $display("FAIL div_drain: got rvalid=%b busy=%b want 0 0", rvalid, busy); else passed++;
    $display("div 100/7 with colliding mult 6*7");
  endtask

  task automatic test_div_zero();
    drive(3'd4, 1'b0, 32'd9, 32'd0, 32'd0, 6'd4);
    total++; if (gnt !== 1'b1) $display("FAIL dz_gnt: got %b want 1", gnt); else passed++;
    drive(3'd4, 1'b1, 32'd20, 32'd6, 32'd0, 6'd5);
    for (int k = 1; k <= 3; k++) begin
      total++; if (gnt !== 1'b0) $display("FAIL div2_hold: cycle %0d got %b want 0", k, gnt); else passed++;
      if (k < 3) begin @(negedge clk); #1; end
    end
    @(negedge clk); #1;
    total++; if (gnt !== 1'b1) $display("FAIL div2_gnt: got %b want 1", gnt); else passed++;
    total++; if ({rvalid, rdata, rflags, rtag} !== {1'b1, 32'hFFFF_FFFF, 5'b00001, 6'd4})
      $display("FAIL dz_result: got v=%b d=%h f=%h t=%0d want v=1 d=ffffffff f=01 t=4", rvalid, rdata, rflags, rtag); else passed++;
    idle(); idle(); idle(); idle();
    total++; if ({rvalid, rdata, rflags, rtag} !== {1'b1, 32'd2, 5'd0, 6'd5})
      $display("FAIL div_rem: got v=%b d=%0d f=%h t=%0d want v=1 d=2 f=00 t=5", rvalid, rdata, rflags, rtag); else passed++;
    idle();
    $display("div 9/0 then 20%%6 back to back");
  endtask

  task automatic test_sqrt_mac();
    drive(3'd5, 1'b0, 32'd1000000, 32'd0, 32'd0, 6'd6);
    total++; if (gnt !== 1'b1) $display("FAIL sqrt_gnt: got %b want 1", gnt); else passed++;
    idle(); idle(); idle(); idle();
    total++; if (rvalid !== 1'b0) $display("FAIL sqrt_early: got %b want 0", rvalid); else passed++;
    drive(3'd5, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd7);
    total++; if (gnt !== 1'b1) $display("FAIL sqrt2_gnt: got %b want 1", gnt); else passed++;
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd1000, 6'd6})
      $display("FAIL sqrt_result: got v=%b d=%0d t=%0d want v=1 d=1000 t=6", rvalid, rdata, rtag); else passed++;
    idle(); idle(); idle(); idle(); idle();
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd65535, 6'd7})
      $display("FAIL sqrt_max: got v=%b d=%0d t=%0d want v=1 d=65535 t=7", rvalid, rdata, rtag); else passed++;
    drive(3'd3, 1'b0, 32'd3, 32'd4, 32'd5, 6'd8);
    total++; if (gnt !== 1'b1) $display("FAIL mac_gnt: got %b want 1", gnt); else passed++;
    idle();
    total++; if (rvalid !== 1'b0) $display("FAIL mac_early: got %b want 0", rvalid); else passed++;
    idle();
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd17, 6'd8})
      $display("FAIL mac_result: got v=%b d=%0d t=%0d want v=1 d=17 t=8", rvalid, rdata, rtag); else passed++;
    idle();
    $display("sqrt 1000000, sqrt 0xffffffff, mac 3*4+5");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  vt [4] = '{3'd1, 3'd2, 3'd2, 3'd6};
    logic        vo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] va [4] = '{32'hFFFF_FFFE, 32'h1234_8001, 32'h1234_8001, 32'd9};
    logic [31:0] ve [4] = '{32'hFFFF_FFFF, 32'hFFFF_8001, 32'h0000_8001, 32'd0};
    logic [4:0]  vf [4] = '{5'd0, 5'd0, 5'd0, 5'b10000};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        drive(vt[i], vo[i], va[i], 32'd3, 32'd0, 6'(10 + i));
        total++; if (gnt !== 1'b1) $display("FAIL b2b_gnt[%0d]: got %b want 1", i, gnt); else passed++;
      end else begin
        idle();
      end
      if (i > 0) begin
        total++; if ({rvalid, rdata, rflags, rtag} !== {1'b1, ve[i-1], vf[i-1], 6'(9 + i)})
          $display("FAIL b2b_result[%0d]: got v=%b d=%h f=%h t=%0d want v=1 d=%h f=%h t=%0d",
                   i - 1, rvalid, rdata, rflags, rtag, ve[i-1], vf[i-1], 9 + i); else passed++;
      end
    end
    idle();
    $display("back-to-back mulh, cast sext, cast zext, invalid type");
  endtask

  task automatic test_out_of_order();
    drive(3'd4, 1'b0, 32'd50, 32'd5, 32'd0, 6'd20);
    drive(3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 6'd21);
    total++; if (gnt !== 1'b1) $display("FAIL ooo_gnt: got %b want 1", gnt); else passed++;
    idle();
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd2, 6'd21})
      $display("FAIL ooo_first: got v=%b d=%0d t=%0d want v=1 d=2 t=21", rvalid, rdata, rtag); else passed++;
    idle(); idle();
    total++; if ({rvalid, rdata, rtag} !== {1'b1, 32'd10, 6'd20})
      $display("FAIL ooo_second: got v=%b d=%0d t=%0d want v=1 d=10 t=20", rvalid, rdata, rtag); else passed++;
    idle();
    $display("div 50/5 overtaken by add 1+1");
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive(3'd3, 1'b0, 32'd2, 32'd2, 32'd2, 6'd30);
    total++; if (gnt !== 1'b1) $display("FAIL rmid_gnt: got %b want 1", gnt); else passed++;
    drive(3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 6'd31);
    rst_n = 1'b0;
    #1;
    total++; if ({gnt, busy, rvalid} !== 3'b000)
      $display("FAIL rmid_in_reset: got gnt=%b busy=%b rvalid=%b want 0 0 0", gnt, busy, rvalid); else passed++;
    idle();
    total++; if ({gnt, busy} !== 2'b00) $display("FAIL rmid_hold: got gnt=%b busy=%b want 0 0", gnt, busy); else passed++;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (rvalid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rmid_no_result: got rvalid seen=%b want 0", seen); else passed++;
    $display("mac aborted by mid-flight reset");
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; utype = '0; op = '0; operands = '0; dflags = '0; tag = '0;
    test_reset();
    test_addsub();
    test_div_collision();
    test_div_zero();
    test_sqrt_mac();
    test_back_to_back();
    test_out_of_order();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apu_int_responder.md
# apu_int_responder

Responder end of the core's APU request/grant/result interface. It accepts one operation per cycle from a single core and executes it in integer stand-in units, one per APU unit class (addsub, mult, cast, mac, div, sqrt). Each result returns after that class's fixed pipeline latency from `apu_core_package`. The block sits on the cluster side of the shared-APU port and supports APU bring-up and verification without the FP units.

## Interface
- `APU_NARGS_CPU`, 3: operand count.
- `APU_WOP_CPU`, 6: op field width.
- `APU_NDSFLAGS_CPU`, 15: downstream flag width; accepted, ignored.
- `APU_NUSFLAGS_CPU`, 5: upstream flag width.
- `TAG_W`, 6: request tag width.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `apu_slave_req_i` in 1: request valid.
- `apu_slave_gnt_o` out 1: grant; combinational, same cycle as req.
- `apu_slave_type_i` in 3: unit class.
- `apu_slave_op_i` in `APU_WOP_CPU`: op variant; only bit 0 is used.
- `apu_slave_operands_i` in `APU_NARGS_CPU`x32: operands a, b, c.
- `apu_slave_flags_i` in `APU_NDSFLAGS_CPU`: unused.
- `apu_slave_tag_i` in `TAG_W`: writeback tag.
- `apu_slave_rvalid_o` out 1: result valid, one-cycle pulse.
- `apu_slave_rdata_o` out 32: result.
- `apu_slave_rflags_o` out `APU_NUSFLAGS_CPU`: result flags.
- `apu_slave_rtag_o` out `TAG_W`: tag of result.
- `busy_o` out 1: anything in flight.

## Operation
- Latencies L: addsub `PIPE_REG_ADDSUB`=1, mult `PIPE_REG_MULT`=1, cast `PIPE_REG_CAST`=1, mac `PIPE_REG_MAC`=2, div `PIPE_REG_DIV`=4, sqrt `PIPE_REG_SQRT`=5. Types 6–7 use L=1.
- The result is computed at grant. It is stored with its tag and flags in result slot L.
- Arithmetic, all 32-bit:
  - type 0 ADDSUB: op0=0 gives a+b, op0=1 gives a−b. rflags[1] = signed overflow.
  - type 1 MULT: op0=0 gives low 32 bits of a*b. op0=1 gives high 32 bits of the signed product.
  - type 2 CAST: op0=0 sign-extends a[15:0]. op0=1 zero-extends a[15:0].
  - type 3 MAC: low 32 bits of a*b+c.
  - type 4 DIV, unsigned: op0=0 gives quotient, op0=1 gives remainder. If b=0: quotient 0xFFFFFFFF, remainder a, rflags[0]=1.
  - type 5 SQRT: floor(sqrt(a)), a unsigned.
  - types 6–7: rdata 0, rflags[4]=1 (invalid).
  - All other flag bits are 0.
- Result slots 1..5 each hold {valid, data, flags, tag}. Every cycle slot[j] ← slot[j+1]; slot[5] ← empty unless written by a grant.
- Outputs `rvalid/rdata/rflags/rtag` are registered from slot[1]. `rvalid` is low when slot[1] is empty.
- `gnt` = `req` AND collision-free AND (not div/sqrt, OR `iter_cnt`==0). Reset asserted forces `gnt`=0.
  - Collision-free means L=5, or slot[L+1] is empty.
- `iter_cnt`, 3 bits: loaded with L−1 on a div/sqrt grant. Decrements while nonzero. Div and sqrt share one non-pipelined unit.
- `busy_o` = any slot valid OR `iter_cnt`≠0.
- Handshake: the core holds req, type, op, operands and tag stable until gnt. Results cannot be back-pressured.

## Timing
- Grant in cycle t: `rvalid` is high in cycle t+L for exactly one cycle. At most one result per cycle.
- Results may return out of issue order; tags identify them.
- A grant and a result delivery may occur in the same cycle.
- A new div/sqrt may be granted in the same cycle as the previous div/sqrt result (cycle t+L).
- Reset values: all slots empty, `iter_cnt`=0, `rvalid`=0, `rdata`=0, `rflags`=0, `rtag`=0, `busy_o`=0.
- Reset mid-operation discards all in-flight work. No result is delivered after reset release.
- Max throughput is 1/cycle for L=1 streams. Div/sqrt throughput is 1 per L cycles.

## Structure
- `apu_core_package` additions:
  - type codes `APU_TYPE_ADDSUB`..`APU_TYPE_SQRT` = 0..5
  - flag bit indices `APU_RFLAG_DZ`=0, `APU_RFLAG_OV`=1, `APU_RFLAG_NV`=4
  - `APU_MAX_LAT`=5
  - the latencies are taken from the existing `PIPE_REG_*` constants
- The slot line and grant logic live inline.
- One sub-module: `apu_int_isqrt`, a combinational 32-bit floor square root.

## Test plan
- ADDSUB a=5, b=7, op0=0, tag=3 at t → gnt at t; rvalid at t+1, rdata=12, rtag=3, rflags=0.
- ADDSUB a=0x7FFFFFFF, b=1 → rdata=0x80000000, rflags[1]=1.
- DIV a=100, b=7 granted at t; MULT req at t+3 → gnt low at t+3, high at t+4. DIV result 14 at t+4; MULT result at t+5.
- DIV a=9, b=0 at t → rdata=0xFFFFFFFF, rflags[0]=1 at t+4. A second DIV held from t+1 is granted at t+4.
- SQRT a=1000000 → 1000 at t+5. SQRT a=0xFFFFFFFF → 65535. MAC 3*4+5 → 17 at t+2.
- MAC granted at t, rst_n low at t+1 → no rvalid ever; busy_o=0 and gnt=0 during reset.
